// File: rtl/spram_64k.sv
// spram_64k: 64K x 32 single-port synchronous RAM built from eight 8K-word banks.
// Optional second output register: define SPRAM64K_OREG_EN for 2-cycle read latency.
module spram_64k #(
    parameter int ASZ = 16,
    parameter int DSZ = 32,
    parameter int BSZ = 13
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [ASZ-1:0] a,
    input  logic [DSZ-1:0] vi,
    output logic [DSZ-1:0] vo
);

    localparam int SSZ = ASZ - BSZ;
    localparam int NB  = 1 << SSZ;
    localparam int BW  = 1 << BSZ;

    logic [SSZ-1:0]         bsel;
    logic [BSZ-1:0]         widx;
    logic [SSZ-1:0]         sel_q;
    logic [NB-1:0][DSZ-1:0] bank_dout;
    logic [DSZ-1:0]         mux_out;

    assign bsel = a[ASZ-1:BSZ];
    assign widx = a[BSZ-1:0];

    // Each bank owns its storage and its own read register, mirroring a
    // block-RAM primitive with a resettable output latch.
    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [DSZ-1:0] mem [BW];
        logic [DSZ-1:0] rd_q;
        logic           en;

        assign en = (bsel == SSZ'(b));

        always_ff @(posedge clk) begin
            if (!rst && we && en) begin
                mem[widx] <= vi;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
            end else if (!we && en) begin
                rd_q <= mem[widx];
            end
        end

        assign bank_dout[b] = rd_q;
    end

    // Bank select only advances on reads so vo holds across write cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
        end else if (!we) begin
            sel_q <= bsel;
        end
    end

    assign mux_out = bank_dout[sel_q];

`ifdef SPRAM64K_OREG_EN
    logic [DSZ-1:0] vo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vo_q <= '0;
        end else if (!we) begin
            vo_q <= mux_out;
        end
    end

    assign vo = vo_q;
`else
    assign vo = mux_out;
`endif

endmodule

// File: tb/tb_spram_64k.sv
// tb_spram_64k: directed plus randomized checks of spram_64k against a word-level model.
// Honors SPRAM64K_OREG_EN the same way as the design.
module tb_spram_64k;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [15:0] a   = '0;
    logic [31:0] vi  = '0;
    logic [31:0] vo;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [int];
    logic [31:0] e1 = 'x;
    logic [31:0] e2 = 'x;

`ifdef SPRAM64K_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    spram_64k dut (
        .clk(clk),
        .rst(rst),
        .we (we),
        .a  (a),
        .vi (vi),
        .vo (vo)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_vo();
        return (LAT == 2) ? e2 : e1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        if (!$isunknown(exp)) begin
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [15:0] ad,
                        input logic [31:0] d, input string tag);
        rst = r; we = w; a = ad; vi = d;
        @(posedge clk);
        if (r) begin
            e1 = '0;
            e2 = '0;
        end else if (w) begin
            mem_m[int'(ad)] = d;
        end else begin
            e2 = e1;
            e1 = mem_m.exists(int'(ad)) ? mem_m[int'(ad)] : 'x;
        end
        #1;
        check(tag, vo, exp_vo());
    endtask

    task automatic wr(input logic [15:0] ad, input logic [31:0] d);
        step(1'b0, 1'b1, ad, d, "write_hold");
    endtask

    task automatic rd_settle(input logic [15:0] ad);
        for (int k = 0; k < LAT; k++) step(1'b0, 1'b0, ad, $urandom, "read");
    endtask

    initial begin
        logic [31:0] v;
        logic [15:0] ra;
        @(posedge clk);
        #1;

        // reset with a write attempt that must be suppressed
        step(1'b1, 1'b1, 16'h0000, 32'hDEADBEEF, "reset_vo");
        step(1'b1, 1'b1, 16'h0000, 32'hDEADBEEF, "reset_vo");
        check("reset_vo_zero", vo, 32'h0);
        rd_settle(16'h0000);
        checks++;
        assert (vo !== 32'hDEADBEEF) else begin
            errors++;
            $error("FAIL reset_write_suppressed observed=%h expected=not_deadbeef", vo);
        end

        // walking-one addresses
        for (int i = 0; i < 16; i++) begin
            v = 32'(-i) << i;
            wr(16'(1 << i), v);
        end
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 16'(1 << i), $urandom, "walk_read");
        rd_settle(16'h0001); check("walk_0001", vo, 32'h00000000);
        rd_settle(16'h0008); check("walk_0008", vo, 32'hFFFFFFE8);
        rd_settle(16'h8000); check("walk_8000", vo, 32'hFFF88000);

        // latency
        wr(16'h1234, 32'hCAFEF00D);
        step(1'b0, 1'b0, 16'h1234, 32'h0, "lat_read");
`ifdef SPRAM64K_OREG_EN
        check("lat_prior", vo, 32'hFFF88000);
        step(1'b0, 1'b0, 16'h1234, 32'h0, "lat_read2");
`endif
        check("lat_value", vo, 32'hCAFEF00D);

        // bank isolation at offset 5 across all eight banks
        wr(16'h0005, 32'h11111111);
        wr(16'hE005, 32'h22222222);
        rd_settle(16'h0005); check("iso_0005", vo, 32'h11111111);
        rd_settle(16'hE005); check("iso_E005", vo, 32'h22222222);
        for (int b = 1; b < 7; b++) wr(16'((b << 13) | 5), 32'(b) * 32'h01010101);
        for (int b = 0; b < 8; b++) step(1'b0, 1'b0, 16'((b << 13) | 5), 32'h0, "iso_bank");
        rd_settle(16'h0005); check("iso_0005_again", vo, 32'h11111111);

        // read-during-write hold
        wr(16'h0010, 32'hA5A5A5A5);
        rd_settle(16'h0010); check("rdw_first", vo, 32'hA5A5A5A5);
        wr(16'h0010, 32'h5A5A5A5A);
        check("rdw_hold", vo, 32'hA5A5A5A5);
        rd_settle(16'h0010); check("rdw_new", vo, 32'h5A5A5A5A);

        // back-to-back reads across the extremes
        wr(16'hFFFF, 32'h0BADF00D);
        wr(16'h0000, 32'h13572468);
        wr(16'h7FFF, 32'h76543210);
        step(1'b0, 1'b0, 16'hFFFF, 32'h0, "b2b_ffff");
        step(1'b0, 1'b0, 16'h0000, 32'h0, "b2b_0000");
        step(1'b0, 1'b0, 16'h7FFF, 32'h0, "b2b_7fff");
        step(1'b0, 1'b0, 16'h7FFF, 32'h0, "b2b_tail");
        check("b2b_last", vo, 32'h76543210);

        // randomized traffic with occasional mid-stream resets
        for (int n = 0; n < 2000; n++) begin
            ra = 16'(($urandom_range(0, 7) << 13) | $urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0)
                step(1'b1, $urandom_range(0, 1) == 1, ra, $urandom, "rand_rst");
            else
                step(1'b0, $urandom_range(0, 9) < 4, ra, $urandom, "rand_op");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
